// File: rtl/pipe_reg_bank_if.sv
// rtl/pipe_reg_bank_if.sv - handshake/data bundle between two pipeline stages around pipe_reg_bank
interface pipe_reg_bank_if #(
  parameter int NCH = 2,
  parameter int W   = 32
);
  logic             in_valid_i;
  logic             in_ready_o;
  logic [NCH*W-1:0] in_data_i;
  logic [NCH-1:0]   we_i;
  logic             flush_i;
  logic             out_valid_o;
  logic             out_ready_i;
  logic [NCH*W-1:0] out_data_o;

  modport slave (
    input  in_valid_i, in_data_i, we_i, flush_i, out_ready_i,
    output in_ready_o, out_valid_o, out_data_o
  );

  modport master (
    output in_valid_i, in_data_i, we_i, flush_i, out_ready_i,
    input  in_ready_o, out_valid_o, out_data_o
  );
endinterface

// File: rtl/pipe_reg_bank.sv
// rtl/pipe_reg_bank.sv - masked, flushable pipeline register bank; NCH channels of W bits
// Define PIPE_REG_BANK_SKID_EN for a two-entry skid buffer with registered in_ready_o.
module pipe_reg_bank #(
  parameter int NCH = 2,
  parameter int W   = 32
) (
  input  logic          clk_i,
  input  logic          rst_i,
  pipe_reg_bank_if.slave bus
);
  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    FULL  = 2'd1,
    SKID  = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [NCH*W-1:0] main_q, main_d;
  logic [NCH*W-1:0] base_q, base_d;
  logic [NCH*W-1:0] merged;
  logic             in_ready, out_valid, accept, consume;
`ifdef PIPE_REG_BANK_SKID_EN
  logic [NCH*W-1:0] skid_q, skid_d;
`endif

  // Masked-off channels take their value from the last accepted beat.
  always_comb begin
    merged = base_q;
    for (int c = 0; c < NCH; c++) begin
      if (bus.we_i[c]) merged[c*W +: W] = bus.in_data_i[c*W +: W];
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= EMPTY;
      main_q  <= '0;
      base_q  <= '0;
`ifdef PIPE_REG_BANK_SKID_EN
      skid_q  <= '0;
`endif
    end else begin
      state_q <= state_d;
      main_q  <= main_d;
      base_q  <= base_d;
`ifdef PIPE_REG_BANK_SKID_EN
      skid_q  <= skid_d;
`endif
    end
  end

  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    base_d  = base_q;
`ifdef PIPE_REG_BANK_SKID_EN
    skid_d  = skid_q;
`endif
    // A beat accepted during flush is dropped and leaves the merge base alone.
    if (bus.flush_i) begin
      state_d = EMPTY;
    end else begin
      if (accept) base_d = merged;
      case (state_q)
        EMPTY: begin
          if (accept) begin
            state_d = FULL;
            main_d  = merged;
          end
        end
        FULL: begin
`ifdef PIPE_REG_BANK_SKID_EN
          if (accept && consume) begin
            main_d = merged;
          end else if (accept) begin
            state_d = SKID;
            skid_d  = merged;
          end else if (consume) begin
            state_d = EMPTY;
          end
`else
          if (accept) begin
            main_d = merged;
          end else if (consume) begin
            state_d = EMPTY;
          end
`endif
        end
`ifdef PIPE_REG_BANK_SKID_EN
        SKID: begin
          if (consume) begin
            state_d = FULL;
            main_d  = skid_q;
          end
        end
`endif
        default: state_d = EMPTY;
      endcase
    end
  end

  always_comb begin
    out_valid = (state_q != EMPTY);
`ifdef PIPE_REG_BANK_SKID_EN
    in_ready  = (state_q != SKID);
`else
    in_ready  = !out_valid || bus.out_ready_i;
`endif
  end

  assign accept          = bus.in_valid_i && in_ready;
  assign consume         = out_valid && bus.out_ready_i;
  assign bus.in_ready_o  = in_ready;
  assign bus.out_valid_o = out_valid;
  assign bus.out_data_o  = main_q;
endmodule
